seg7_scan_ctrl: RTL
===================

// Module: seg7_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//   Accepts a packed hex/BCD word over a valid/ready handshake and cycles one digit at a time.
//   Drives that digit's nibble through a hex-to-segment decoder with a registered anode select.
//   Inserts a blanking guard between digits to suppress ghosting.
//   Sits between the system datapath and the board display pins.
// PARAMETERS
//   NUM_DIGITS    4   digits scanned; range 2..8
//   TICK_DIV      8   clk cycles per digit slot (BLANK + SHOW); >= 2
//   BLANK_CYCLES  2   anodes-off guard at slot start; 0..TICK_DIV-1 (0 = no guard)
// PORTS
//   clk         in   1             rising-edge clock
//   rst_n       in   1             synchronous reset, active-low
//   en          in   1             scan enable; low = display dark
//   load_valid  in   1             new display word offered
//   load_ready  out  1             controller can accept a word
//   load_data   in   4*NUM_DIGITS  digit i = load_data[4i+3:4i]; digit 0 = rightmost
//   an          out  NUM_DIGITS    anode selects, active-low, registered
//   seg         out  7             segments {g,f,e,d,c,b,a}, active-low, registered
// BEHAVIOUR
//   Reset (rst_n low at clk edge):
//     - an='1, seg=7'h7F; state=IDLE; idx=0; slot counter=0
//     - active and shadow registers cleared to 0; pending=0; load_ready=1
//   Handshake: word accepted on the cycle where load_valid && load_ready.
//     - IDLE: accepted word is written directly to the active register; pending stays 0.
//     - Otherwise the word goes to the shadow register; pending=1; load_ready=!pending.
//     - While pending, load_ready=0 and load_valid is ignored.
//   Commit point: shadow->active and pending->0 on the cycle idx wraps NUM_DIGITS-1 -> 0.
//     - The frame containing that wrap shows no tearing; a frame never mixes old and new words.
//   FSM states and transitions:
//     - IDLE: an='1, seg='1. en=1 -> BLANK (idx=0, cnt=0) next cycle.
//     - BLANK: an='1; lasts BLANK_CYCLES cycles, then -> SHOW. Skipped when BLANK_CYCLES=0.
//     - SHOW: an[idx]=0, others 1; seg=decode(active[idx]); lasts TICK_DIV-BLANK_CYCLES cycles.
//       Then idx=(idx+1) mod NUM_DIGITS and -> BLANK (or SHOW if BLANK_CYCLES=0).
//   Timing and arithmetic:
//     - Outputs are registered: the value reflects the state one cycle after the state is entered.
//     - Frame period = NUM_DIGITS*TICK_DIV cycles exactly.
//     - cnt width = $clog2(TICK_DIV); idx width = $clog2(NUM_DIGITS); both wrap explicitly.
//   en deasserted in any state -> IDLE next cycle; an='1, seg='1 the following cycle; idx=0.
//     - A pending shadow word is committed on the IDLE entry.
//   load_valid accepted in the same cycle as the frame wrap: the word stays in shadow until the next wrap.
//   Decode, hex, active-low, a=bit0:
//     0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E
// CONFIGURATION
//   SEG7_LZB_EN defined: leading-zero blanking.
//     - A digit is blanked (seg=7'h7F, anode still asserted) if it and every higher digit are 0.
//     - Digit 0 is never blanked.
//   SEG7_LZB_EN undefined: every digit is always decoded; no LZB logic is present.
// STRUCTURE
//   Package seg7_pkg:
//     - typedef enum logic [1:0] {S_IDLE,S_BLANK,S_SHOW} scan_state_t
//     - localparam logic [6:0] SEG_OFF=7'h7F
//     - function hex2seg(logic [3:0]) returning the table above
//   Sub-module seg7_hex_decode: combinational nibble->segment wrapper around hex2seg.
//     - Instantiated once in the controller; its output is registered.
// TESTING
//   1. Defaults, load 16'h1234 with en=1.
//      -> Digit 0..3 show seg 19,30,24,79 in turn.
//      -> an sequence 1110,1101,1011,0111, each low for 6 cycles, preceded by 2 cycles of 1111.
//   2. Load 16'hABCD mid-frame. -> load_ready=0 until the wrap.
//      -> The remainder of the frame still shows 1234; the next frame shows ABCD.
//      -> A second load_valid during pending is not accepted.
//   3. Deassert en during SHOW of digit 2. -> an=1111, seg=7F within 2 cycles.
//      -> Re-enable: scan restarts at digit 0 after the BLANK guard.
//   4. Pulse rst_n low mid-frame. -> Next cycle an=1111, seg=7F, load_ready=1.
//      -> A later enable shows 0000 (seg 40 on all digits).
//   5. BLANK_CYCLES=0, TICK_DIV=2. -> No all-off gaps; each anode low exactly 2 cycles; frame=8 cycles.
//   6. SEG7_LZB_EN defined, load 16'h0050. -> Digits 3,2 seg=7F, digit 1 seg=12, digit 0 seg=40.
//      -> Load 16'h0000: only digit 0 is lit (seg=40).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared scan-state encoding, blank segment pattern and hex-to-segment table for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        hex2seg = SEG_OFF;
        case (nib)
            4'h0: hex2seg = 7'h40;
            4'h1: hex2seg = 7'h79;
            4'h2: hex2seg = 7'h24;
            4'h3: hex2seg = 7'h30;
            4'h4: hex2seg = 7'h19;
            4'h5: hex2seg = 7'h12;
            4'h6: hex2seg = 7'h02;
            4'h7: hex2seg = 7'h78;
            4'h8: hex2seg = 7'h00;
            4'h9: hex2seg = 7'h18;
            4'hA: hex2seg = 7'h08;
            4'hB: hex2seg = 7'h03;
            4'hC: hex2seg = 7'h46;
            4'hD: hex2seg = 7'h21;
            4'hE: hex2seg = 7'h06;
            4'hF: hex2seg = 7'h0E;
            default: hex2seg = SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder; zero latency, no handshake.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex2seg(nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit common-anode scan controller: outputs registered one cycle after the scan state; load_ready drops while a word waits in shadow.
// Define SEG7_LZB_EN to blank leading zero digits (digit 0 is always shown).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    scan_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [DW-1:0] active, shadow;
    logic          pending;
    logic          accept;
    logic          frame_wrap;
    logic          commit;
    logic [3:0]    nib;
    logic [6:0]    nib_seg;
    logic          lz_blank;

    assign load_ready = !pending;
    assign accept     = load_valid && load_ready;
    assign frame_wrap = (state == S_SHOW) && (cnt == TICK_LAST) && (idx == IDX_LAST);
    // Shadow moves to active only at a frame boundary or when the scan goes dark
    assign commit     = pending && (frame_wrap || !en || (state == S_IDLE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (accept) begin
            if (state == S_IDLE) begin
                active <= load_data;
            end else begin
                shadow  <= load_data;
                pending <= 1'b1;
            end
        end else if (commit) begin
            active  <= shadow;
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (!en) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
                end
                S_BLANK: begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == BLANK_LAST) begin
                        state_nxt = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (cnt == TICK_LAST) begin
                        cnt_nxt   = '0;
                        idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                        state_nxt = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign nib = active[{idx, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nib (nib),
        .seg (nib_seg)
    );

`ifdef SEG7_LZB_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  higher_zero;

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        lz_mask     = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            higher_zero = higher_zero && (active[4*i +: 4] == 4'h0);
            lz_mask[i]  = higher_zero;
        end
    end

    assign lz_blank = lz_mask[idx];
`else
    assign lz_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else if (state == S_SHOW) begin
            an  <= ~(AN_ONE << idx);
            seg <= lz_blank ? SEG_OFF : nib_seg;
        end else begin
            an  <= '1;
            seg <= SEG_OFF;
        end
    end

endmodule
